wt_ram_arbiter: RTL and testbench

Arbitrates the single-port accelerator weight RAM between three requesters: host loader (write/read), conv layer (read) and full-connect layer (read).
- Round-robin arbitration with bounded bursts.
- Tags read returns back to the issuing requester.
- Sits between the layer engines, the bus-side weight loader and the weight RAM macro.

---
 rtl/wt_ram_arbiter_if.sv | 51 +++++
 rtl/wt_ram_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_wt_ram_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wt_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// wt_ram_arbiter_if
// Bundle of the weight-RAM arbiter buses: three requester ports (host
// loader write/read, conv read, fc read), the single-port RAM macro port and
// the shared read-return signals.
//   slave  : view used by the arbiter (takes requests, drives the RAM)
//   master : view used by the requesters / RAM side around the arbiter
// Parameters: AW address width, DW data width.
// -----------------------------------------------------------------------------
interface wt_ram_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 192
);
  logic          HostReq_i;
  logic          HostWe_i;
  logic [AW-1:0] HostAddr_i;
  logic [DW-1:0] HostWdata_i;
  logic          HostGnt_o;
  logic          HostRvalid_o;
  logic          ConvReq_i;
  logic [AW-1:0] ConvAddr_i;
  logic          ConvGnt_o;
  logic          ConvRvalid_o;
  logic          FcReq_i;
  logic [AW-1:0] FcAddr_i;
  logic          FcGnt_o;
  logic          FcRvalid_o;
  logic          RamCe_o;
  logic          RamWe_o;
  logic [AW-1:0] RamAddr_o;
  logic [DW-1:0] RamWdata_o;
  logic [DW-1:0] RamRdata_i;
  logic [DW-1:0] Rdata_o;
  logic [1:0]    Owner_o;

  modport slave (
    input  HostReq_i, HostWe_i, HostAddr_i, HostWdata_i,
    input  ConvReq_i, ConvAddr_i, FcReq_i, FcAddr_i, RamRdata_i,
    output HostGnt_o, HostRvalid_o, ConvGnt_o, ConvRvalid_o,
    output FcGnt_o, FcRvalid_o, RamCe_o, RamWe_o, RamAddr_o,
    output RamWdata_o, Rdata_o, Owner_o
  );

  modport master (
    output HostReq_i, HostWe_i, HostAddr_i, HostWdata_i,
    output ConvReq_i, ConvAddr_i, FcReq_i, FcAddr_i, RamRdata_i,
    input  HostGnt_o, HostRvalid_o, ConvGnt_o, ConvRvalid_o,
    input  FcGnt_o, FcRvalid_o, RamCe_o, RamWe_o, RamAddr_o,
    input  RamWdata_o, Rdata_o, Owner_o
  );
endinterface

// File: rtl/wt_ram_arbiter.sv
// -----------------------------------------------------------------------------
// wt_ram_arbiter
// Shares the single-port weight RAM between the host loader (read/write),
// the conv engine (read) and the fc engine (read). Round-robin ownership with
// bursts bounded to MAX_BURST beats while someone else waits; every read beat
// is tagged with its requester so the Rvalid pulse RD_LAT cycles later goes
// back to whoever issued it, even across owner changes.
// Ports:
//   clk   clock
//   rstn  synchronous active-low reset
//   bus   wt_ram_arbiter_if.slave (requester Req/Addr/Gnt/Rvalid, RAM port,
//         shared Rdata_o, Owner_o: 0 none, 1 host, 2 conv, 3 fc)
// Optional build macro: HOST_PRIO_EN -- host always wins arbitration and
// preempts a conv/fc owner after its current beat; round-robin is then kept
// only between conv and fc.
// -----------------------------------------------------------------------------
module wt_ram_arbiter #(
  parameter int AW        = 9,
  parameter int DW        = 192,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  wt_ram_arbiter_if.slave   bus
);

  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_HOST = 2'd1;
  localparam logic [1:0] OWN_CONV = 2'd2;
  localparam logic [1:0] OWN_FC   = 2'd3;

`ifdef HOST_PRIO_EN
  localparam logic [1:0] PTR_RST = OWN_CONV;
`else
  localparam logic [1:0] PTR_RST = OWN_HOST;
`endif

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e        state_r;
  logic [1:0]    owner_r;
  logic [1:0]    ptr_r;                 // requester with highest priority
  logic [CW-1:0] cnt_r;
  logic [1:0]    tag_r [RD_LAT];        // owner code of each read in flight

  logic          own_req_s;
  logic          beat_s;
  logic          wr_beat_s;
  logic          others_s;
  logic          burst_end_s;
  logic          preempt_s;
  logic          release_s;
  logic [1:0]    winner_s;

  // First requester set in req (bit0 host, bit1 conv, bit2 fc) scanning from 'first'
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] first);
    logic [1:0] cand;
    logic [1:0] res;
    res  = OWN_NONE;
    cand = first;
    for (int k = 0; k < 3; k++) begin
      if ((res == OWN_NONE) && (cand != OWN_NONE) && req[cand - 2'd1]) begin
        res = cand;
      end else begin
        res = res;
      end
      cand = (cand == OWN_FC) ? OWN_HOST : cand + 2'd1;
    end
    return res;
  endfunction

  // Priority pointer after 'own' gives up the RAM
  function automatic logic [1:0] ptr_after(input logic [1:0] own, input logic [1:0] cur);
    logic [1:0] nxt;
    case (own)
`ifdef HOST_PRIO_EN
      OWN_CONV: nxt = OWN_FC;
      OWN_FC:   nxt = OWN_CONV;
`else
      OWN_HOST: nxt = OWN_CONV;
      OWN_CONV: nxt = OWN_FC;
      OWN_FC:   nxt = OWN_HOST;
`endif
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

  // Owner request, beat detection, release conditions and idle-state winner
  always_comb begin
    case (owner_r)
      OWN_HOST: own_req_s = bus.HostReq_i;
      OWN_CONV: own_req_s = bus.ConvReq_i;
      OWN_FC:   own_req_s = bus.FcReq_i;
      default:  own_req_s = 1'b0;
    endcase
    beat_s      = (state_r == ST_BUSY) && own_req_s;
    wr_beat_s   = beat_s && (owner_r == OWN_HOST) && bus.HostWe_i;
    others_s    = (bus.HostReq_i && (owner_r != OWN_HOST)) ||
                  (bus.ConvReq_i && (owner_r != OWN_CONV)) ||
                  (bus.FcReq_i   && (owner_r != OWN_FC));
    // this beat is the MAX_BURST-th one of the current run
    burst_end_s = (cnt_r == CW'(MAX_BURST - 1));
`ifdef HOST_PRIO_EN
    preempt_s   = bus.HostReq_i && ((owner_r == OWN_CONV) || (owner_r == OWN_FC));
    if (bus.HostReq_i) begin
      winner_s = OWN_HOST;
    end else begin
      winner_s = rr_pick({bus.FcReq_i, bus.ConvReq_i, 1'b0}, ptr_r);
    end
`else
    preempt_s   = 1'b0;
    winner_s    = rr_pick({bus.FcReq_i, bus.ConvReq_i, bus.HostReq_i}, ptr_r);
`endif
    release_s   = (state_r == ST_BUSY) &&
                  (!own_req_s || (burst_end_s && others_s) || preempt_s);
  end

  // Ownership FSM, burst counter and read-tag pipeline
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      owner_r <= OWN_NONE;
      ptr_r   <= PTR_RST;
      cnt_r   <= CW'(0);
      for (int i = 0; i < RD_LAT; i++) begin
        tag_r[i] <= OWN_NONE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= CW'(0);
          if (winner_s != OWN_NONE) begin
            owner_r <= winner_s;
            state_r <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (release_s) begin
            state_r <= ST_IDLE;
            owner_r <= OWN_NONE;
            cnt_r   <= CW'(0);
            ptr_r   <= ptr_after(owner_r, ptr_r);
          end else if (beat_s) begin
            // alone at MAX_BURST: wrap and keep the RAM
            cnt_r <= burst_end_s ? CW'(0) : cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          owner_r <= OWN_NONE;
          cnt_r   <= CW'(0);
        end
      endcase
      tag_r[0] <= (beat_s && !wr_beat_s) ? owner_r : OWN_NONE;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  // Grant and RAM port drive for the current beat
  always_comb begin
    bus.HostGnt_o  = 1'b0;
    bus.ConvGnt_o  = 1'b0;
    bus.FcGnt_o    = 1'b0;
    bus.RamCe_o    = beat_s;
    bus.RamWe_o    = wr_beat_s;
    bus.RamAddr_o  = AW'(0);
    bus.RamWdata_o = (owner_r == OWN_HOST) ? bus.HostWdata_i : DW'(0);
    if (beat_s) begin
      case (owner_r)
        OWN_HOST: begin
          bus.HostGnt_o = 1'b1;
          bus.RamAddr_o = bus.HostAddr_i;
        end
        OWN_CONV: begin
          bus.ConvGnt_o = 1'b1;
          bus.RamAddr_o = bus.ConvAddr_i;
        end
        OWN_FC: begin
          bus.FcGnt_o   = 1'b1;
          bus.RamAddr_o = bus.FcAddr_i;
        end
        default: begin
          bus.RamAddr_o = AW'(0);
        end
      endcase
    end else begin
      bus.RamAddr_o = AW'(0);
    end
  end

  assign bus.HostRvalid_o = (tag_r[RD_LAT-1] == OWN_HOST);
  assign bus.ConvRvalid_o = (tag_r[RD_LAT-1] == OWN_CONV);
  assign bus.FcRvalid_o   = (tag_r[RD_LAT-1] == OWN_FC);
  assign bus.Rdata_o      = bus.RamRdata_i;
  assign bus.Owner_o      = owner_r;

endmodule

// File: tb/tb_wt_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wt_ram_arbiter
// Drives directed scenarios followed by randomized requests against
// wt_ram_arbiter plus a behavioural RAM macro, and compares every cycle with
// a reference model built from the arbitration rules (owner/pointer/beat
// count as integers, a shadow memory and a queue of pending read returns).
// -----------------------------------------------------------------------------
module tb_wt_ram_arbiter;
  localparam int AW = 9;
  localparam int DW = 192;
  localparam int MB = 4;
  localparam int RL = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wt_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  wt_ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB), .RD_LAT(RL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] w;
    w = (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
    return {w, ~w, w, ~w, w, 32'(a)};
  endfunction

  // Behavioural RAM macro with RD_LAT read latency
  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] rd_pipe [RL];
  bit filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= init_word(i);
      filled <= 1'b1;
    end else if (bus.RamCe_o && bus.RamWe_o) begin
      ram_mem[bus.RamAddr_o] <= bus.RamWdata_o;
    end
    rd_pipe[0] <= (bus.RamCe_o && !bus.RamWe_o) ? ram_mem[bus.RamAddr_o] : '0;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.RamRdata_i = rd_pipe[RL-1];

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            who;
    logic [DW-1:0] data;
  } ret_t;
  ret_t          pend[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int m_owner;
  int m_ptr;
  int m_cnt;
  int m_last_beat;

`ifdef HOST_PRIO_EN
  localparam int PTR0 = 2;
`else
  localparam int PTR0 = 1;
`endif

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int m_pick(input int r1, input int r2, input int r3);
    int req[4];
    int id;
    req[0] = 0; req[1] = r1; req[2] = r2; req[3] = r3;
`ifdef HOST_PRIO_EN
    if (r1 != 0) return 1;
    for (int k = 0; k < 2; k++) begin
      id = (k == 0) ? m_ptr : 5 - m_ptr;
      if (req[id] != 0) return id;
    end
`else
    for (int k = 0; k < 3; k++) begin
      id = ((m_ptr - 1 + k) % 3) + 1;
      if (req[id] != 0) return id;
    end
`endif
    return 0;
  endfunction

  task automatic m_release();
`ifdef HOST_PRIO_EN
    if (m_owner == 2) m_ptr = 3;
    else if (m_owner == 3) m_ptr = 2;
`else
    m_ptr = (m_owner % 3) + 1;
`endif
    m_owner = 0;
    m_cnt = 0;
  endtask

  // One clock: inputs already applied after a negedge
  task automatic run_cycle();
    int req[4];
    bit beat, we;
    int addr;
    int rv_who;
    logic [DW-1:0] wdata;
    #1;
    req[0] = 0;
    req[1] = int'(bus.HostReq_i);
    req[2] = int'(bus.ConvReq_i);
    req[3] = int'(bus.FcReq_i);
    beat  = (m_owner != 0) && (req[m_owner] != 0);
    we    = beat && (m_owner == 1) && bus.HostWe_i;
    addr  = !beat ? 0 : (m_owner == 1) ? int'(bus.HostAddr_i) :
            (m_owner == 2) ? int'(bus.ConvAddr_i) : int'(bus.FcAddr_i);
    wdata = (m_owner == 1) ? bus.HostWdata_i : '0;
    rv_who = (pend.size() > 0 && pend[0].due == cyc) ? pend[0].who : 0;

    check_eq("host_gnt",  DW'(bus.HostGnt_o),  DW'(beat && m_owner == 1));
    check_eq("conv_gnt",  DW'(bus.ConvGnt_o),  DW'(beat && m_owner == 2));
    check_eq("fc_gnt",    DW'(bus.FcGnt_o),    DW'(beat && m_owner == 3));
    check_eq("ram_ce",    DW'(bus.RamCe_o),    DW'(beat));
    check_eq("ram_we",    DW'(bus.RamWe_o),    DW'(we));
    check_eq("ram_addr",  DW'(bus.RamAddr_o),  DW'(addr));
    check_eq("ram_wdata", bus.RamWdata_o,      wdata);
    check_eq("owner",     DW'(bus.Owner_o),    DW'(m_owner));
    check_eq("host_rv",   DW'(bus.HostRvalid_o), DW'(rv_who == 1));
    check_eq("conv_rv",   DW'(bus.ConvRvalid_o), DW'(rv_who == 2));
    check_eq("fc_rv",     DW'(bus.FcRvalid_o),   DW'(rv_who == 3));
    if (rv_who != 0) check_eq("rdata", bus.Rdata_o, pend[0].data);

    m_last_beat = beat ? m_owner : 0;
    @(posedge clk);
    if (rv_who != 0) void'(pend.pop_front());
    if (!rstn) begin
      m_owner = 0; m_cnt = 0; m_ptr = PTR0;
      pend.delete();
    end else begin
      if (beat) begin
        if (we) ref_mem[addr] = wdata;
        else pend.push_back('{due: cyc + RL, who: m_owner, data: ref_mem[addr]});
      end
      if (m_owner == 0) begin
        m_owner = m_pick(req[1], req[2], req[3]);
        m_cnt = 0;
      end else if (!beat) begin
        m_release();
      end else begin
        m_cnt++;
`ifdef HOST_PRIO_EN
        if (m_owner != 1 && req[1] != 0) m_release();
        else
`endif
        if (m_cnt == MB) begin
          if ((req[1] + req[2] + req[3] - req[m_owner]) != 0) m_release();
          else m_cnt = 0;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.HostReq_i = 1'b0; bus.ConvReq_i = 1'b0; bus.FcReq_i = 1'b0;
  endtask

  // Run until 'n' beats for requester 'who' (address advances per beat), bounded
  task automatic wait_beats(input int who, input int n, input int budget, input string tag);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      run_cycle();
      if (m_last_beat == who) begin
        got++;
        if (who == 1) bus.HostAddr_i = bus.HostAddr_i + 1'b1;
        else if (who == 2) bus.ConvAddr_i = bus.ConvAddr_i + 1'b1;
        else bus.FcAddr_i = bus.FcAddr_i + 1'b1;
      end
    end
    check_eq(tag, DW'(got), DW'(n));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    m_owner = 0; m_ptr = PTR0; m_cnt = 0; m_last_beat = 0;
    idle_inputs();
    bus.HostWe_i = 1'b0; bus.HostAddr_i = '0; bus.HostWdata_i = '0;
    bus.ConvAddr_i = '0; bus.FcAddr_i = '0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    repeat (2) run_cycle();              // reset state checked by the model
    rstn = 1'b1;

    // conv reads 5,6,7
    bus.ConvReq_i = 1'b1; bus.ConvAddr_i = 9'd5;
    wait_beats(2, 3, 10, "conv_3beats");
    idle_inputs(); repeat (4) run_cycle();

    // host writes A5.. to addr 3, conv reads it back
    bus.HostReq_i = 1'b1; bus.HostWe_i = 1'b1; bus.HostAddr_i = 9'd3;
    bus.HostWdata_i = {24{8'hA5}};
    wait_beats(1, 1, 10, "host_wr");
    idle_inputs(); bus.HostWe_i = 1'b0;
    bus.ConvReq_i = 1'b1; bus.ConvAddr_i = 9'd3;
    wait_beats(2, 1, 10, "conv_rd3");
    idle_inputs(); repeat (4) run_cycle();
    check_eq("ram_a5", ram_mem[3], {24{8'hA5}});

    // conv and fc competing continuously
    bus.ConvReq_i = 1'b1; bus.FcReq_i = 1'b1;
    repeat (30) run_cycle();
    idle_inputs(); repeat (4) run_cycle();

    // fc drops after 2 beats while host waits
    bus.FcReq_i = 1'b1; bus.FcAddr_i = 9'd40;
    wait_beats(3, 1, 10, "fc_beat1");
    bus.HostReq_i = 1'b1; bus.HostWe_i = 1'b0; bus.HostAddr_i = 9'd7;
    wait_beats(3, 1, 10, "fc_beat2");
    bus.FcReq_i = 1'b0;
    wait_beats(1, 2, 10, "host_after_fc");
    idle_inputs(); repeat (4) run_cycle();

    // reset mid-burst with a read in flight
    bus.ConvReq_i = 1'b1; bus.ConvAddr_i = 9'd20;
    wait_beats(2, 2, 10, "conv_pre_rst");
    idle_inputs(); rstn = 1'b0;
    run_cycle();
    rstn = 1'b1;
    run_cycle();                          // dropped return would show here
    bus.HostReq_i = 1'b1; bus.ConvReq_i = 1'b1; bus.FcReq_i = 1'b1;
    run_cycle();
    check_eq("post_rst_owner", DW'(bus.Owner_o), DW'(1));
    run_cycle();
    idle_inputs(); repeat (4) run_cycle();

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        rstn = 1'b0; idle_inputs();
      end else begin
        rstn = 1'b1;
        if ($urandom_range(0, 3) == 0) bus.HostReq_i = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 3) == 0) bus.ConvReq_i = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) == 0) bus.FcReq_i   = ($urandom_range(0, 2) != 0);
        bus.HostWe_i    = ($urandom_range(0, 1) == 1);
        bus.HostAddr_i  = AW'($urandom_range(0, 31));
        bus.ConvAddr_i  = AW'($urandom_range(0, 31));
        bus.FcAddr_i    = AW'($urandom_range(0, 31));
        bus.HostWdata_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      run_cycle();
    end
    rstn = 1'b1; idle_inputs();
    repeat (6) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
